regfile_port_scheduler: RTL and testbench

Sequences the single-port 32x32 register file (one index, 1-cycle registered read, write on posedge) between the decode stage and the writeback stage. Owns the per-register hazard flags (regFlag[n] scoreboard). It fetches up to two source operands serially for each accepted instruction, grants writeback absolute priority on the port, and stalls decode on RAW/WAW hazards. It sits between decode, execute and writeback, and it is the only driver of the register file's index, readEnable, writeEnable and valueInput.

---
 rtl/regfile_port_scheduler.sv | 171 +++++++++++++++++
 tb/tb_regfile_port_scheduler.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_port_scheduler.sv
// Port scheduler for a single-port register file: serial operand fetch for
// decode, absolute writeback priority on the port, and a RAW/WAW scoreboard.
module regfile_port_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int IDX_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dec_valid,
  output logic                  dec_ready,
  input  logic [IDX_WIDTH-1:0]  dec_rs1,
  input  logic [IDX_WIDTH-1:0]  dec_rs2,
  input  logic                  dec_uses_rs2,
  input  logic [IDX_WIDTH-1:0]  dec_rd,
  input  logic                  dec_writes_rd,
  output logic                  op_valid,
  input  logic                  op_ready,
  output logic [DATA_WIDTH-1:0] op_a,
  output logic [DATA_WIDTH-1:0] op_b,
  output logic [IDX_WIDTH-1:0]  op_rd,
  output logic                  op_writes_rd,
  input  logic                  wb_valid,
  input  logic [IDX_WIDTH-1:0]  wb_rd,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic [IDX_WIDTH-1:0]  rf_index,
  output logic                  rf_read_en,
  output logic                  rf_write_en,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  input  logic [DATA_WIDTH-1:0] rf_rdata,
  output logic [NUM_REGS-1:0]   busy_flags
);

  // state | meaning
  // IDLE  | waiting for a hazard-free decode instruction
  // RD_A  | issue source A read (or zero it for x0)
  // RD_B  | issue source B read (or zero it if unused / x0)
  // WAIT  | capture the last outstanding read
  // OUT   | operands held for execute until op_ready
  typedef enum logic [2:0] {IDLE, RD_A, RD_B, WAIT, OUT} state_t;
  typedef enum logic [1:0] {PEND_NONE, PEND_A, PEND_B} pend_t;

  state_t                state_q;
  pend_t                 pend_q;
  logic [NUM_REGS-1:0]   busy_q, busy_d;
  logic                  op_valid_q;
  logic [DATA_WIDTH-1:0] op_a_q, op_b_q;
  logic [IDX_WIDTH-1:0]  op_rd_q;
  logic                  op_writes_rd_q;
  logic [IDX_WIDTH-1:0]  rs1_q, rs2_q;
  logic                  uses_rs2_q;

  logic wb_take;
  logic hazard;
  logic accept;
  logic need_a, need_b;
  logic rd_issue;

  assign wb_take   = reset & wb_valid & (wb_rd != '0);
  assign hazard    = busy_q[dec_rs1]
                   | (dec_uses_rs2 & busy_q[dec_rs2])
                   | (dec_writes_rd & busy_q[dec_rd]);
  assign dec_ready = reset & (state_q == IDLE) & ~hazard;
  assign accept    = dec_valid & dec_ready;
  assign need_a    = (rs1_q != '0);
  assign need_b    = uses_rs2_q & (rs2_q != '0);

  // Writeback owns the port whenever it targets a real register.
  always_comb begin
    rf_write_en = 1'b0;
    rf_read_en  = 1'b0;
    rf_index    = '0;
    rf_wdata    = '0;
    rd_issue    = 1'b0;
    if (wb_take) begin
      rf_write_en = 1'b1;
      rf_index    = wb_rd;
      rf_wdata    = wb_data;
    end else if (reset && state_q == RD_A && need_a) begin
      rf_read_en = 1'b1;
      rf_index   = rs1_q;
      rd_issue   = 1'b1;
    end else if (reset && state_q == RD_B && need_b) begin
      rf_read_en = 1'b1;
      rf_index   = rs2_q;
      rd_issue   = 1'b1;
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (wb_valid) busy_d[wb_rd] = 1'b0;
    if (accept && dec_writes_rd && dec_rd != '0) busy_d[dec_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= IDLE;
      pend_q         <= PEND_NONE;
      busy_q         <= '0;
      op_valid_q     <= 1'b0;
      op_a_q         <= '0;
      op_b_q         <= '0;
      op_rd_q        <= '0;
      op_writes_rd_q <= 1'b0;
      rs1_q          <= '0;
      rs2_q          <= '0;
      uses_rs2_q     <= 1'b0;
    end else begin
      busy_q <= busy_d;
      pend_q <= PEND_NONE;
      // The register file holds its output when no read is issued, so the
      // capture is valid even if writeback stole the port this cycle.
      case (pend_q)
        PEND_A:  op_a_q <= rf_rdata;
        PEND_B:  op_b_q <= rf_rdata;
        default: ;
      endcase
      case (state_q)
        IDLE: begin
          if (accept) begin
            rs1_q          <= dec_rs1;
            rs2_q          <= dec_rs2;
            uses_rs2_q     <= dec_uses_rs2;
            op_rd_q        <= dec_rd;
            op_writes_rd_q <= dec_writes_rd;
            state_q        <= RD_A;
          end
        end
        RD_A: begin
          if (!need_a) begin
            op_a_q  <= '0;
            state_q <= RD_B;
          end else if (rd_issue) begin
            pend_q  <= PEND_A;
            state_q <= RD_B;
          end
        end
        RD_B: begin
          if (!need_b) begin
            op_b_q  <= '0;
            state_q <= WAIT;
          end else if (rd_issue) begin
            pend_q  <= PEND_B;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          op_valid_q <= 1'b1;
          state_q    <= OUT;
        end
        OUT: begin
          if (op_ready) begin
            op_valid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign op_valid     = op_valid_q;
  assign op_a         = op_a_q;
  assign op_b         = op_b_q;
  assign op_rd        = op_rd_q;
  assign op_writes_rd = op_writes_rd_q;
  assign busy_flags   = busy_q;

endmodule

// File: tb/tb_regfile_port_scheduler.sv
// Directed bench for regfile_port_scheduler with a behavioural single-port
// register file (1-cycle registered read, write on posedge).
module tb_regfile_port_scheduler;

  logic        clk;
  logic        reset;
  logic        dec_valid, dec_ready;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        dec_uses_rs2, dec_writes_rd;
  logic        op_valid, op_ready;
  logic [31:0] op_a, op_b;
  logic [4:0]  op_rd;
  logic        op_writes_rd;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [4:0]  rf_index;
  logic        rf_read_en, rf_write_en;
  logic [31:0] rf_wdata, rf_rdata;
  logic [31:0] busy_flags;

  int errors = 0;
  int checks = 0;

  regfile_port_scheduler dut (
    .clk(clk), .reset(reset),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_uses_rs2(dec_uses_rs2),
    .dec_rd(dec_rd), .dec_writes_rd(dec_writes_rd),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .op_rd(op_rd), .op_writes_rd(op_writes_rd),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .rf_index(rf_index), .rf_read_en(rf_read_en), .rf_write_en(rf_write_en),
    .rf_wdata(rf_wdata), .rf_rdata(rf_rdata), .busy_flags(busy_flags)
  );

  logic [31:0] rf_mem [32];
  always_ff @(posedge clk) begin
    if (rf_write_en) rf_mem[rf_index] <= rf_wdata;
    if (rf_read_en)  rf_rdata <= rf_mem[rf_index];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_uses_rs2 = 0;
    dec_rd = 0; dec_writes_rd = 0; op_ready = 0;
    wb_valid = 0; wb_rd = 0; wb_data = 0;
  endtask

  task automatic wb_write(input logic [4:0] idx, input logic [31:0] data);
    wb_valid = 1; wb_rd = idx; wb_data = data;
    tick();
    wb_valid = 0;
  endtask

  task automatic present(input logic [4:0] rs1, input logic [4:0] rs2, input logic uses,
                         input logic [4:0] rd, input logic wr);
    dec_valid = 1; dec_rs1 = rs1; dec_rs2 = rs2; dec_uses_rs2 = uses;
    dec_rd = rd; dec_writes_rd = wr;
  endtask

  task automatic handshake();
    op_ready = 1;
    tick();
    op_ready = 0;
  endtask

  task automatic test_reset();
    reset = 0;
    present(5'd1, 5'd2, 1, 5'd3, 1);
    wb_valid = 1; wb_rd = 5'd3; wb_data = 32'h55;
    tick(); tick();
    #1;
    checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL reset_dec_ready: got %b exp 0", dec_ready); end
    checks++; if (rf_write_en !== 1'b0) begin errors++; $display("FAIL reset_write_en: got %b exp 0", rf_write_en); end
    checks++; if (rf_read_en !== 1'b0) begin errors++; $display("FAIL reset_read_en: got %b exp 0", rf_read_en); end
    checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL reset_op_valid: got %b exp 0", op_valid); end
    checks++; if (busy_flags !== 32'h0) begin errors++; $display("FAIL reset_busy: got %h exp 0", busy_flags); end
    checks++; if (op_a !== 32'h0) begin errors++; $display("FAIL reset_op_a: got %h exp 0", op_a); end
    idle_inputs();
    reset = 1;
    tick();
    wb_valid = 1; wb_rd = 5'd3; wb_data = 32'h11;
    #1;
    checks++; if ({rf_write_en, rf_read_en, rf_index, rf_wdata} !== {1'b1, 1'b0, 5'd3, 32'h11})
      begin errors++; $display("FAIL wb_port: got we=%b re=%b idx=%0d d=%h exp we=1 re=0 idx=3 d=11", rf_write_en, rf_read_en, rf_index, rf_wdata); end
    tick();
    wb_valid = 0;
    wb_write(5'd4, 32'h22);
    wb_write(5'd9, 32'h99);
  endtask

  task automatic test_basic();
    int n;
    present(5'd3, 5'd4, 1, 5'd5, 1);
    #1;
    checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL basic_ready: got %b exp 1", dec_ready); end
    tick();
    dec_valid = 0;
    #1;
    checks++; if ({rf_read_en, rf_index} !== {1'b1, 5'd3}) begin errors++; $display("FAIL basic_read_a: got re=%b idx=%0d exp re=1 idx=3", rf_read_en, rf_index); end
    checks++; if (busy_flags !== 32'h20) begin errors++; $display("FAIL basic_busy: got %h exp 20", busy_flags); end
    tick(); #1;
    checks++; if ({rf_read_en, rf_index} !== {1'b1, 5'd4}) begin errors++; $display("FAIL basic_read_b: got re=%b idx=%0d exp re=1 idx=4", rf_read_en, rf_index); end
    n = 2;
    while (!op_valid && n < 20) begin tick(); #1; n++; end
    checks++; if (n !== 4) begin errors++; $display("FAIL basic_latency: got %0d exp 4", n); end
    checks++; if (op_a !== 32'h11) begin errors++; $display("FAIL basic_op_a: got %h exp 11", op_a); end
    checks++; if (op_b !== 32'h22) begin errors++; $display("FAIL basic_op_b: got %h exp 22", op_b); end
    checks++; if ({op_rd, op_writes_rd} !== {5'd5, 1'b1}) begin errors++; $display("FAIL basic_op_rd: got %0d/%b exp 5/1", op_rd, op_writes_rd); end
    handshake(); #1;
    checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL basic_op_valid_drop: got %b exp 0", op_valid); end
  endtask

  task automatic test_raw_stall();
    int n;
    present(5'd5, 5'd0, 0, 5'd6, 1);
    #1;
    checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL raw_stall: got %b exp 0", dec_ready); end
    tick(); #1;
    checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL raw_stall_hold: got %b exp 0", dec_ready); end
    wb_valid = 1; wb_rd = 5'd5; wb_data = 32'hABCD;
    #1;
    checks++; if ({rf_write_en, rf_read_en} !== 2'b10) begin errors++; $display("FAIL raw_wb_port: got we=%b re=%b exp we=1 re=0", rf_write_en, rf_read_en); end
    tick();
    wb_valid = 0;
    #1;
    checks++; if (busy_flags !== 32'h0) begin errors++; $display("FAIL raw_busy_clear: got %h exp 0", busy_flags); end
    checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL raw_ready_after_wb: got %b exp 1", dec_ready); end
    tick();
    dec_valid = 0;
    n = 1; #1;
    while (!op_valid && n < 20) begin tick(); #1; n++; end
    checks++; if (n !== 4) begin errors++; $display("FAIL raw_latency: got %0d exp 4", n); end
    checks++; if (op_a !== 32'hABCD) begin errors++; $display("FAIL raw_op_a: got %h exp abcd", op_a); end
    checks++; if (op_b !== 32'h0) begin errors++; $display("FAIL raw_op_b_unused: got %h exp 0", op_b); end
    checks++; if (busy_flags !== 32'h40) begin errors++; $display("FAIL raw_busy_rd6: got %h exp 40", busy_flags); end
    handshake();
    wb_write(5'd6, 32'h66);
  endtask

  task automatic test_port_steal();
    int n;
    present(5'd3, 5'd4, 1, 5'd0, 0);
    #1;
    tick();
    dec_valid = 0;
    for (int i = 0; i < 3; i++) begin
      wb_valid = 1; wb_rd = 5'(10 + i); wb_data = 32'h100 + i;
      #1;
      checks++; if ({rf_read_en, rf_write_en} !== 2'b01) begin errors++; $display("FAIL steal_cycle%0d: got re=%b we=%b exp re=0 we=1", i, rf_read_en, rf_write_en); end
      tick();
    end
    wb_valid = 0;
    #1;
    checks++; if ({rf_read_en, rf_index} !== {1'b1, 5'd3}) begin errors++; $display("FAIL steal_resume: got re=%b idx=%0d exp re=1 idx=3", rf_read_en, rf_index); end
    n = 4;
    while (!op_valid && n < 30) begin tick(); #1; n++; end
    checks++; if (n !== 7) begin errors++; $display("FAIL steal_latency: got %0d exp 7", n); end
    checks++; if (op_a !== 32'h11) begin errors++; $display("FAIL steal_op_a: got %h exp 11", op_a); end
    checks++; if (op_b !== 32'h22) begin errors++; $display("FAIL steal_op_b: got %h exp 22", op_b); end
    handshake();
    present(5'd10, 5'd12, 1, 5'd0, 0);
    tick();
    dec_valid = 0;
    n = 1; #1;
    while (!op_valid && n < 20) begin tick(); #1; n++; end
    checks++; if (op_a !== 32'h100) begin errors++; $display("FAIL steal_wb_landed_a: got %h exp 100", op_a); end
    checks++; if (op_b !== 32'h102) begin errors++; $display("FAIL steal_wb_landed_b: got %h exp 102", op_b); end
    handshake();
  endtask

  task automatic test_x0();
    int n;
    int reads;
    present(5'd0, 5'd0, 1, 5'd0, 1);
    #1;
    checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL x0_ready: got %b exp 1", dec_ready); end
    tick();
    dec_valid = 0;
    wb_valid = 1; wb_rd = 5'd0; wb_data = 32'hDEAD;
    #1;
    checks++; if (rf_write_en !== 1'b0) begin errors++; $display("FAIL x0_wb_write_en: got %b exp 0", rf_write_en); end
    reads = int'(rf_read_en);
    tick();
    wb_valid = 0;
    #1;
    n = 2;
    reads += int'(rf_read_en);
    while (!op_valid && n < 20) begin tick(); #1; n++; reads += int'(rf_read_en); end
    checks++; if (reads !== 0) begin errors++; $display("FAIL x0_no_reads: got %0d exp 0", reads); end
    checks++; if (n !== 4) begin errors++; $display("FAIL x0_latency: got %0d exp 4", n); end
    checks++; if ({op_a, op_b} !== 64'h0) begin errors++; $display("FAIL x0_operands: got %h/%h exp 0/0", op_a, op_b); end
    checks++; if (busy_flags !== 32'h0) begin errors++; $display("FAIL x0_busy: got %h exp 0", busy_flags); end
    handshake();
  endtask

  task automatic test_same_cycle();
    int n;
    present(5'd9, 5'd0, 0, 5'd7, 1);
    wb_valid = 1; wb_rd = 5'd7; wb_data = 32'h77;
    #1;
    checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL same_ready: got %b exp 1", dec_ready); end
    tick();
    dec_valid = 0; wb_valid = 0;
    #1;
    checks++; if (busy_flags !== 32'h80) begin errors++; $display("FAIL same_set_wins: got %h exp 80", busy_flags); end
    n = 1;
    while (!op_valid && n < 20) begin tick(); #1; n++; end
    checks++; if (op_a !== 32'h99) begin errors++; $display("FAIL same_op_a: got %h exp 99", op_a); end
    handshake();
    wb_write(5'd7, 32'h70);
    #1;
    checks++; if (busy_flags !== 32'h0) begin errors++; $display("FAIL same_busy_cleared: got %h exp 0", busy_flags); end
  endtask

  task automatic test_reset_mid();
    int n;
    present(5'd3, 5'd4, 1, 5'd9, 1);
    #1;
    tick();
    dec_valid = 0;
    #1;
    checks++; if (busy_flags !== 32'h200) begin errors++; $display("FAIL mid_busy_set: got %h exp 200", busy_flags); end
    tick();
    reset = 0;
    #1;
    checks++; if ({rf_read_en, dec_ready} !== 2'b00) begin errors++; $display("FAIL mid_forced_low: got re=%b rdy=%b exp 0/0", rf_read_en, dec_ready); end
    tick();
    reset = 1;
    #1;
    checks++; if (busy_flags !== 32'h0) begin errors++; $display("FAIL mid_busy_cleared: got %h exp 0", busy_flags); end
    checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL mid_op_valid: got %b exp 0", op_valid); end
    checks++; if ({rf_read_en, rf_write_en} !== 2'b00) begin errors++; $display("FAIL mid_rf_en: got re=%b we=%b exp 0/0", rf_read_en, rf_write_en); end
    present(5'd9, 5'd0, 0, 5'd9, 1);
    #1;
    checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL mid_idle_ready: got %b exp 1", dec_ready); end
    tick();
    dec_valid = 0;
    n = 1; #1;
    while (!op_valid && n < 20) begin tick(); #1; n++; end
    checks++; if (n !== 4) begin errors++; $display("FAIL mid_latency: got %0d exp 4", n); end
    checks++; if (op_a !== 32'h99) begin errors++; $display("FAIL mid_op_a: got %h exp 99", op_a); end
    handshake();
  endtask

  initial begin
    idle_inputs();
    reset = 0;
    tick();
    test_reset();
    test_basic();
    test_raw_stall();
    test_port_steal();
    test_x0();
    test_same_cycle();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
